// File: rtl/inst_decode_pkg.sv
// rtl/inst_decode_pkg.sv - RV32I opcodes, instruction formats and decode helpers
package inst_decode_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h2000_0000;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  // One decoded instruction as held in the decode/execute pipeline register
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        is_load;
    logic        illegal;
  } dec_t;

  function automatic fmt_e opc_fmt(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_OP:                                               f = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: f = FMT_I;
      OPC_STORE:                                            f = FMT_S;
      OPC_BRANCH:                                           f = FMT_B;
      OPC_LUI, OPC_AUIPC:                                   f = FMT_U;
      OPC_JAL:                                              f = FMT_J;
      default:                                              f = FMT_BAD;
    endcase
    return f;
  endfunction

  // R-format and unknown opcodes carry no immediate
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input fmt_e f);
    logic [31:0] imm;
    case (f)
      FMT_I:   imm = {{20{i[31]}}, i[31:20]};
      FMT_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   imm = {i[31:12], 12'b0};
      FMT_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/inst_decode_reg_file.sv
// rtl/inst_decode_reg_file.sv - 32x32 register file, x0 hardwired, 2R1W with write-through
module inst_decode_reg_file #(
  parameter bit REG_INIT_ZERO = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o
);

  logic [31:0] regs_q [32];
  logic        wr_ok;

  assign wr_ok = we_i && (waddr_i != 5'd0);

  generate
    if (REG_INIT_ZERO) begin : g_clr
      // Register write with async clear of the whole array
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
        end else if (wr_ok) begin
          regs_q[waddr_i] <= wdata_i;
        end
      end
    end else begin : g_noclr
      // Register write, contents left unreset
      always_ff @(posedge clk_i) begin
        if (wr_ok) regs_q[waddr_i] <= wdata_i;
      end
    end
  endgenerate

  // Reads see a same-cycle write so decode never latches a stale operand
  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'h0 :
                     (wr_ok && waddr_i == raddr_a_i) ? wdata_i : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'h0 :
                     (wr_ok && waddr_i == raddr_b_i) ? wdata_i : regs_q[raddr_b_i];

endmodule

// File: rtl/inst_decode.sv
// rtl/inst_decode.sv - RV32I decode stage with regfile read and load-use bubble
module inst_decode
  import inst_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter bit          REG_INIT_ZERO = 1'b1
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] I_PC,
  input  logic [31:0] I_INST,
  input  logic        I_VALID,
  input  logic        W_RD_EN,
  input  logic [4:0]  W_RD_ADDR,
  input  logic [31:0] W_RD_DATA,
  output logic        LOAD_STALL,
  output logic        D_VALID,
  output logic [31:0] D_PC,
  output logic [31:0] D_INST,
  output logic [6:0]  D_OPCODE,
  output logic [2:0]  D_FUNCT3,
  output logic [6:0]  D_FUNCT7,
  output logic [4:0]  D_RD_ADDR,
  output logic [4:0]  D_RS1_ADDR,
  output logic [4:0]  D_RS2_ADDR,
  output logic [31:0] D_RS1_DATA,
  output logic [31:0] D_RS2_DATA,
  output logic [31:0] D_IMM,
  output logic        D_IS_LOAD,
  output logic        D_ILLEGAL
);

  fmt_e        fmt;
  logic        use_rs1, use_rs2;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [31:0] rs1_rdata, rs2_rdata;
  logic        load_hazard;
  logic        w_hit1, w_hit2;
  dec_t        d_d, d_q;

  inst_decode_reg_file #(.REG_INIT_ZERO(REG_INIT_ZERO)) u_rf (
    .clk_i     (CLK),
    .rst_ni    (RSTN),
    .we_i      (W_RD_EN),
    .waddr_i   (W_RD_ADDR),
    .wdata_i   (W_RD_DATA),
    .raddr_a_i (rs1_a),
    .rdata_a_o (rs1_rdata),
    .raddr_b_i (rs2_a),
    .rdata_b_o (rs2_rdata)
  );

  // Field extraction; register indices a format does not use are zeroed
  always_comb begin
    fmt     = opc_fmt(I_INST[6:0]);
    use_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    use_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
    rd_a    = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : I_INST[11:7];
    rs1_a   = (fmt == FMT_U || fmt == FMT_J) ? 5'd0 : I_INST[19:15];
    rs2_a   = use_rs2 ? I_INST[24:20] : 5'd0;
  end

  // A held instruction cannot bubble; the hazard is re-checked once STALL drops
  assign load_hazard = I_VALID && d_q.valid && d_q.is_load && (d_q.rd != 5'd0) &&
                       ((use_rs1 && rs1_a == d_q.rd) || (use_rs2 && rs2_a == d_q.rd)) &&
                       !FLUSH && !STALL;

  assign w_hit1 = W_RD_EN && (W_RD_ADDR != 5'd0) && (W_RD_ADDR == d_q.rs1);
  assign w_hit2 = W_RD_EN && (W_RD_ADDR != 5'd0) && (W_RD_ADDR == d_q.rs2);

  // Next pipeline register value: FLUSH > STALL > load bubble > accept
  always_comb begin
    d_d = d_q;
    if (FLUSH) begin
      d_d    = '0;
      d_d.pc = RESET_PC;
    end else if (STALL) begin
      if (w_hit1) d_d.rs1_data = W_RD_DATA;
      if (w_hit2) d_d.rs2_data = W_RD_DATA;
    end else if (load_hazard) begin
      d_d.valid = 1'b0;
    end else if (I_VALID && I_INST != 32'h0) begin
      d_d.valid    = 1'b1;
      d_d.pc       = I_PC;
      d_d.inst     = I_INST;
      d_d.rd       = rd_a;
      d_d.rs1      = rs1_a;
      d_d.rs2      = rs2_a;
      d_d.rs1_data = rs1_rdata;
      d_d.rs2_data = rs2_rdata;
      d_d.imm      = imm_gen(I_INST, fmt);
      d_d.is_load  = (I_INST[6:0] == OPC_LOAD);
      d_d.illegal  = (fmt == FMT_BAD);
    end else begin
      d_d.valid = 1'b0;
    end
  end

  // Decode/execute pipeline register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      d_q    <= '0;
      d_q.pc <= RESET_PC;
    end else begin
      d_q <= d_d;
    end
  end

  assign LOAD_STALL = load_hazard;
  assign D_VALID    = d_q.valid;
  assign D_PC       = d_q.pc;
  assign D_INST     = d_q.inst;
  assign D_OPCODE   = d_q.inst[6:0];
  assign D_FUNCT3   = d_q.inst[14:12];
  assign D_FUNCT7   = d_q.inst[31:25];
  assign D_RD_ADDR  = d_q.rd;
  assign D_RS1_ADDR = d_q.rs1;
  assign D_RS2_ADDR = d_q.rs2;
  assign D_RS1_DATA = d_q.rs1_data;
  assign D_RS2_DATA = d_q.rs2_data;
  assign D_IMM      = d_q.imm;
  assign D_IS_LOAD  = d_q.is_load;
  assign D_ILLEGAL  = d_q.illegal;

endmodule
